fc_tx_scheduler: RTL and testbench

FC_TX_SCHEDULER -- requirements
Module: fc_tx_scheduler

---
 rtl/fc_tx_scheduler_if.sv | 36 +++
 rtl/fc_tx_scheduler.sv | 136 +++++++++++++
 tb/tb_fc_tx_scheduler.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fc_tx_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fc_tx_scheduler_if                                              |
// | Brief    : Credit-update, request and grant signals of the TX scheduler.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface fc_tx_scheduler_if;
   logic        fc_upd_valid_i;
   logic [7:0]  fc_upd_hdr_i;
   logic [11:0] fc_upd_data_i;
   logic [2:0]  req_valid_i;
   logic [23:0] req_size_i;
   logic        tx_done_i;
   logic [2:0]  gnt_o;
   logic [7:0]  gnt_hdr_credit_o;
   logic [11:0] gnt_data_credit_o;
   logic [7:0]  cc_hdr_o;
   logic [11:0] cc_data_o;
   logic        fc_ready_o;
   logic        stall_o;

   modport slave (
      input  fc_upd_valid_i, fc_upd_hdr_i, fc_upd_data_i,
      input  req_valid_i, req_size_i, tx_done_i,
      output gnt_o, gnt_hdr_credit_o, gnt_data_credit_o,
      output cc_hdr_o, cc_data_o, fc_ready_o, stall_o
   );

   modport master (
      output fc_upd_valid_i, fc_upd_hdr_i, fc_upd_data_i,
      output req_valid_i, req_size_i, tx_done_i,
      input  gnt_o, gnt_hdr_credit_o, gnt_data_credit_o,
      input  cc_hdr_o, cc_data_o, fc_ready_o, stall_o
   );
endinterface
`default_nettype wire

// File: rtl/fc_tx_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fc_tx_scheduler                                                 |
// | Brief    : Credit-gated round-robin TLP grant for MWr / MRd / Cpl sources. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fc_tx_scheduler (
   input  logic               clk,
   input  logic               rst_n,
   fc_tx_scheduler_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_GRANT = 2'd2
   } state_t;

   localparam logic [7:0]  c_HDR_COST = 8'd1;
   localparam logic [7:0]  c_HDR_LIM  = 8'h80;
   localparam logic [11:0] c_DATA_LIM = 12'h800;
   localparam logic [2:0]  c_HAS_DATA = 3'b101;

   state_t      r_state;
   logic [7:0]  r_cl_hdr;
   logic [11:0] r_cl_data;
   logic [7:0]  r_cc_hdr;
   logic [11:0] r_cc_data;
   logic [2:0]  r_gnt;
   logic [7:0]  r_gnt_hdr;
   logic [11:0] r_gnt_data;
   logic        r_fc_ready;
   logic [1:0]  r_last;

   logic [11:0] w_cost_data [3];
   logic [2:0]  w_pass;
   logic [2:0]  w_eligible;
   logic [1:0]  w_sel;
   logic        w_any;
   logic [11:0] w_sel_data;

   // Payload is charged in 4-DW units, rounded up; MRd carries no payload.
   for (genvar gi = 0; gi < 3; gi++) begin : g_src
      logic [7:0]  w_hdr_cr;
      logic [11:0] w_data_cr;

      assign w_cost_data[gi] = ((({4'd0, bus.req_size_i[8*gi +: 8]} + 12'd3) >> 2))
                               & {12{c_HAS_DATA[gi]}};
      assign w_hdr_cr  = r_cl_hdr  - (r_cc_hdr  + c_HDR_COST);
      assign w_data_cr = r_cl_data - (r_cc_data + w_cost_data[gi]);
      assign w_pass[gi] = (w_hdr_cr <= c_HDR_LIM) && (w_data_cr <= c_DATA_LIM);
   end

   assign w_eligible = (r_state == ST_IDLE) ? (bus.req_valid_i & w_pass) : 3'b000;
   assign w_any      = (w_eligible != 3'b000);

   // Search starts one past the last granted source and wraps modulo 3.
   always_comb begin
      logic [1:0] v_idx;
      logic       v_found;
      w_sel   = 2'd0;
      v_idx   = r_last;
      v_found = 1'b0;
      for (int k = 0; k < 3; k++) begin
         v_idx = (v_idx == 2'd2) ? 2'd0 : v_idx + 2'd1;
         if (!v_found && w_eligible[v_idx]) begin
            v_found = 1'b1;
            w_sel   = v_idx;
         end
      end
   end

   assign w_sel_data = w_cost_data[w_sel];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_INIT;
         r_cl_hdr   <= 8'd0;
         r_cl_data  <= 12'd0;
         r_cc_hdr   <= 8'd0;
         r_cc_data  <= 12'd0;
         r_gnt      <= 3'b000;
         r_gnt_hdr  <= 8'd0;
         r_gnt_data <= 12'd0;
         r_fc_ready <= 1'b0;
         r_last     <= 2'd2;
      end else begin
         // Limit updates after INIT land at the edge; this cycle's decision used the old limit.
         if (r_state != ST_INIT && bus.fc_upd_valid_i) begin
            r_cl_hdr  <= bus.fc_upd_hdr_i;
            r_cl_data <= bus.fc_upd_data_i;
         end
         case (r_state)
            ST_INIT: begin
               if (bus.fc_upd_valid_i) begin
                  r_cl_hdr   <= bus.fc_upd_hdr_i;
                  r_cl_data  <= bus.fc_upd_data_i;
                  r_fc_ready <= 1'b1;
                  r_state    <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (w_any) begin
                  r_gnt      <= 3'b001 << w_sel;
                  r_gnt_hdr  <= c_HDR_COST;
                  r_gnt_data <= w_sel_data;
                  r_cc_hdr   <= r_cc_hdr + c_HDR_COST;
                  r_cc_data  <= r_cc_data + w_sel_data;
                  r_last     <= w_sel;
                  r_state    <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (bus.tx_done_i) begin
                  r_gnt      <= 3'b000;
                  r_gnt_hdr  <= 8'd0;
                  r_gnt_data <= 12'd0;
                  r_state    <= ST_IDLE;
               end
            end
            default: r_state <= ST_INIT;
         endcase
      end
   end

   assign bus.gnt_o             = r_gnt;
   assign bus.gnt_hdr_credit_o  = r_gnt_hdr;
   assign bus.gnt_data_credit_o = r_gnt_data;
   assign bus.cc_hdr_o          = r_cc_hdr;
   assign bus.cc_data_o         = r_cc_data;
   assign bus.fc_ready_o        = r_fc_ready;
   assign bus.stall_o           = (r_state == ST_IDLE) && r_fc_ready
                                  && (bus.req_valid_i != 3'b000) && !w_any;

endmodule
`default_nettype wire

// File: tb/tb_fc_tx_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fc_tx_scheduler                                              |
// | Brief    : Scoreboard bench for fc_tx_scheduler with a credit-rule model.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_fc_tx_scheduler;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fc_tx_scheduler_if bus ();
   fc_tx_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      int cyc; int gnt; int ready; int stall; int cch; int ccd; int gh; int gd;
   } cyc_rec_t;
   typedef struct {
      int cyc; int gnt; int gh; int gd; int cch; int ccd;
   } gnt_rec_t;

   cyc_rec_t cq[$];
   gnt_rec_t gq[$];
   cyc_rec_t mon_c;
   gnt_rec_t mon_g;
   logic [2:0] prev_gnt = 3'b000;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model state: credit limit, consumed credit, last grant, phase.
   int m_ready, m_in_grant, m_gnt, m_last;
   int m_cl_h, m_cl_d, m_cc_h, m_cc_d, m_gh, m_gd;
   bit m_granted_now;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int dcost(input int s, input int size);
      if (s == 1) return 0;
      return (size + 3) / 4;
   endfunction

   function automatic bit passes(input int s, input int size);
      int h, d;
      h = (m_cl_h - m_cc_h - 1) & 255;
      d = (m_cl_d - m_cc_d - dcost(s, size)) & 4095;
      return (h <= 128) && (d <= 2048);
   endfunction

   task automatic model_reset();
      m_ready = 0; m_in_grant = 0; m_gnt = 0; m_last = 2;
      m_cl_h = 0; m_cl_d = 0; m_cc_h = 0; m_cc_d = 0; m_gh = 0; m_gd = 0;
      m_granted_now = 0;
      cq.delete();
      gq.delete();
   endtask

   // One clock of stimulus; the model predicts this cycle's outputs and the next edge.
   task automatic step(input bit uv, input int uh, input int ud,
                       input bit [2:0] rv, input bit [23:0] sz, input bit done);
      int elig, pick;
      cyc_rec_t cr;
      gnt_rec_t gr;
      @(posedge clk); #1;
      bus.fc_upd_valid_i = uv;
      bus.fc_upd_hdr_i   = uh[7:0];
      bus.fc_upd_data_i  = ud[11:0];
      bus.req_valid_i    = rv;
      bus.req_size_i     = sz;
      bus.tx_done_i      = done;
      m_granted_now = 0;
      elig = 0;
      if (m_ready != 0 && m_in_grant == 0)
         for (int s = 0; s < 3; s++)
            if (rv[s] && passes(s, int'(sz[8*s +: 8]))) elig = elig | (1 << s);
      cr = '{cyc, (m_in_grant != 0) ? (1 << m_gnt) : 0, m_ready,
             (m_ready != 0 && m_in_grant == 0 && rv != 0 && elig == 0) ? 1 : 0,
             m_cc_h, m_cc_d, m_gh, m_gd};
      cq.push_back(cr);
      if (m_ready == 0) begin
         if (uv) begin m_cl_h = uh & 255; m_cl_d = ud & 4095; m_ready = 1; end
      end else begin
         if (m_in_grant == 0 && elig != 0) begin
            pick = -1;
            for (int k = 1; k <= 3; k++)
               if (pick < 0 && elig[(m_last + k) % 3]) pick = (m_last + k) % 3;
            m_gnt = pick; m_gh = 1; m_gd = dcost(pick, int'(sz[8*pick +: 8]));
            m_cc_h = (m_cc_h + 1) & 255;
            m_cc_d = (m_cc_d + m_gd) & 4095;
            m_last = pick; m_in_grant = 1; m_granted_now = 1;
            gr = '{cyc + 1, 1 << pick, m_gh, m_gd, m_cc_h, m_cc_d};
            gq.push_back(gr);
         end else if (m_in_grant != 0 && done) begin
            m_in_grant = 0; m_gh = 0; m_gd = 0;
         end
         if (uv) begin m_cl_h = uh & 255; m_cl_d = ud & 4095; end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.fc_upd_valid_i = 1'b0; bus.fc_upd_hdr_i = 8'd0; bus.fc_upd_data_i = 12'd0;
      bus.req_valid_i = 3'b000; bus.req_size_i = 24'd0; bus.tx_done_i = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      model_reset();
   endtask

   task automatic set_cl(input int h, input int d);
      step(1'b1, h, d, 3'b000, 24'd0, 1'b0);
   endtask

   // Issue an MRd, let it be granted, then complete it.
   task automatic grant_mrd();
      for (int i = 0; i < 4 && !m_granted_now; i++) step(1'b0, 0, 0, 3'b010, 24'd0, 1'b0);
      if (!m_granted_now) chk("mrd_grant_model", 0, 1);
      step(1'b0, 0, 0, 3'b000, 24'd0, 1'b1);
   endtask

   task automatic raise_cc_hdr(input int target);
      for (int it = 0; it < 300 && m_cc_h != target; it++) begin
         set_cl((m_cc_h + 1) & 255, m_cc_d);
         m_granted_now = 0;
         grant_mrd();
      end
   endtask

   // Monitor: per-cycle outputs, and grant contents whenever a new grant appears.
   always @(negedge clk) begin
      if (rst_n) begin
         if (cq.size() != 0 && cq[0].cyc == cyc) begin
            mon_c = cq.pop_front();
            chk("gnt",        32'(bus.gnt_o),             mon_c.gnt);
            chk("fc_ready",   32'(bus.fc_ready_o),        mon_c.ready);
            chk("stall",      32'(bus.stall_o),           mon_c.stall);
            chk("cc_hdr",     32'(bus.cc_hdr_o),          mon_c.cch);
            chk("cc_data",    32'(bus.cc_data_o),         mon_c.ccd);
            chk("gnt_hdr_cr", 32'(bus.gnt_hdr_credit_o),  mon_c.gh);
            chk("gnt_data_cr",32'(bus.gnt_data_credit_o), mon_c.gd);
         end
         chk("gnt_onehot0", 32'($onehot0(bus.gnt_o)), 1);
         if (bus.gnt_o != 3'b000 && prev_gnt == 3'b000) begin
            if (gq.size() == 0) begin
               chk("unexpected_grant", 32'(bus.gnt_o), 0);
            end else begin
               mon_g = gq.pop_front();
               chk("grant_cycle", cyc,                          mon_g.cyc);
               chk("grant_src",   32'(bus.gnt_o),               mon_g.gnt);
               chk("grant_hdr",   32'(bus.gnt_hdr_credit_o),    mon_g.gh);
               chk("grant_data",  32'(bus.gnt_data_credit_o),   mon_g.gd);
               chk("grant_cch",   32'(bus.cc_hdr_o),            mon_g.cch);
               chk("grant_ccd",   32'(bus.cc_data_o),           mon_g.ccd);
            end
         end
         prev_gnt = bus.gnt_o;
      end else begin
         prev_gnt = 3'b000;
      end
   end

   int exp_g [4] = '{1, 2, 4, 1};
   int exp_d [4] = '{4, 4, 8, 12};
   bit [2:0]  t_req;
   bit [23:0] t_sz;

   initial begin
      model_reset();
      do_reset();
      #1 chk("rst_gnt", 32'(bus.gnt_o), 0);
      chk("rst_ready", 32'(bus.fc_ready_o), 0);
      chk("rst_cc_data", 32'(bus.cc_data_o), 0);

      // No limit yet: requests must not be granted.
      repeat (3) step(1'b0, 0, 0, 3'b111, 24'h101010, 1'b0);
      #2 chk("init_no_grant", 32'(bus.gnt_o), 0);
      chk("init_not_ready", 32'(bus.fc_ready_o), 0);
      step(1'b1, 8, 64, 3'b111, 24'h101010, 1'b0);
      step(1'b0, 0, 0, 3'b111, 24'h101010, 1'b0);
      #2 chk("ready_after_upd", 32'(bus.fc_ready_o), 1);
      step(1'b0, 0, 0, 3'b111, 24'h101010, 1'b0);
      #2 chk("first_grant_mwr", 32'(bus.gnt_o), 1);

      // Round-robin over three sizes-16 requesters.
      do_reset();
      set_cl(8, 64);
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4 && !m_granted_now; j++) step(1'b0, 0, 0, 3'b111, 24'h101010, 1'b0);
         m_granted_now = 0;
         step(1'b0, 0, 0, 3'b111, 24'h101010, 1'b1);
         #2 chk("rr_gnt", 32'(bus.gnt_o), exp_g[i]);
         chk("rr_cc_hdr", 32'(bus.cc_hdr_o), i + 1);
         chk("rr_cc_data", 32'(bus.cc_data_o), exp_d[i]);
      end

      // Data credit exactly exhausted, then blocked, then released by an update.
      do_reset();
      set_cl(8, 4);
      step(1'b0, 0, 0, 3'b001, 24'd16, 1'b0);
      step(1'b0, 0, 0, 3'b000, 24'd0, 1'b1);
      #2 chk("exhaust_grant", 32'(bus.gnt_o), 1);
      step(1'b0, 0, 0, 3'b001, 24'd1, 1'b0);
      #2 chk("blocked_stall", 32'(bus.stall_o), 1);
      step(1'b1, 8, 5, 3'b001, 24'd1, 1'b0);
      #2 chk("upd_cycle_stall", 32'(bus.stall_o), 1);
      step(1'b0, 0, 0, 3'b001, 24'd1, 1'b0);
      #2 chk("after_upd_stall", 32'(bus.stall_o), 0);
      step(1'b0, 0, 0, 3'b001, 24'd1, 1'b0);
      #2 chk("after_upd_grant", 32'(bus.gnt_o), 1);
      step(1'b0, 0, 0, 3'b000, 24'd0, 1'b1);

      // Header counter wrap and the 0x80 / 0x81 boundary.
      do_reset();
      set_cl(1, 0);
      m_granted_now = 0;
      raise_cc_hdr(255);
      set_cl(0, m_cc_d);
      m_granted_now = 0;
      grant_mrd();
      #2 chk("wrap_cc_hdr", 32'(bus.cc_hdr_o), 0);
      raise_cc_hdr(8'h7D);
      set_cl(8'hFF, m_cc_d);
      step(1'b0, 0, 0, 3'b010, 24'd0, 1'b0);
      #2 chk("hdr_cr_81_stall", 32'(bus.stall_o), 1);
      step(1'b0, 0, 0, 3'b000, 24'd0, 1'b0);
      raise_cc_hdr(8'h7E);
      set_cl(8'hFF, m_cc_d);
      m_granted_now = 0;
      step(1'b0, 0, 0, 3'b010, 24'd0, 1'b0);
      #2 chk("hdr_cr_80_stall", 32'(bus.stall_o), 0);
      step(1'b0, 0, 0, 3'b000, 24'd0, 1'b1);
      #2 chk("hdr_cr_80_cc", 32'(bus.cc_hdr_o), 8'h7F);
      step(1'b0, 0, 0, 3'b000, 24'd0, 1'b0);

      // Asynchronous reset while a grant is held.
      do_reset();
      set_cl(8, 64);
      step(1'b0, 0, 0, 3'b010, 24'd0, 1'b0);
      step(1'b0, 0, 0, 3'b000, 24'd0, 1'b0);
      #2 chk("pre_rst_gnt", 32'(bus.gnt_o), 2);
      @(posedge clk); #3 rst_n = 1'b0;
      #1 chk("async_gnt", 32'(bus.gnt_o), 0);
      chk("async_cc_hdr", 32'(bus.cc_hdr_o), 0);
      chk("async_cc_data", 32'(bus.cc_data_o), 0);
      do_reset();
      step(1'b0, 0, 0, 3'b111, 24'h101010, 1'b0);
      #2 chk("post_rst_ready", 32'(bus.fc_ready_o), 0);

      // Randomised traffic with occasional limit updates.
      do_reset();
      set_cl(40, 600);
      t_req = 3'b000;
      t_sz  = 24'd0;
      for (int it = 0; it < 2000; it++) begin
         bit uv, dn;
         int h, d;
         uv = ($urandom_range(0, 9) == 0);
         h = ($urandom_range(0, 1) != 0) ? m_cc_h + int'($urandom_range(0, 6)) : int'($urandom_range(0, 255));
         d = ($urandom_range(0, 1) != 0) ? m_cc_d + int'($urandom_range(0, 150)) : int'($urandom_range(0, 4095));
         if (m_in_grant == 0)
            for (int s = 0; s < 3; s++)
               if (!t_req[s] && $urandom_range(0, 2) == 0) begin
                  t_req[s] = 1'b1;
                  t_sz[8*s +: 8] = 8'($urandom_range(0, 255));
               end
         dn = (m_in_grant != 0) && ($urandom_range(0, 2) == 0);
         step(uv, h & 255, d & 4095, t_req, t_sz, dn);
         if (m_granted_now) t_req[m_gnt] = 1'b0;
      end
      step(1'b0, 0, 0, 3'b000, 24'd0, 1'b1);
      step(1'b0, 0, 0, 3'b000, 24'd0, 1'b0);
      @(posedge clk); #3;
      chk("grant_queue_drain", gq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
